// File: rtl/mult_ctrl.sv
// Operand sequencer and 2-entry result FIFO sitting in front of the iterative multiplier.
// Issues one operation at a time, enforces the begin-low gap, and aborts a hung multiplier.
module mult_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  output logic             mult_begin,
  output logic [31:0]      mult_op1,
  output logic [31:0]      mult_op2,
  input  logic [63:0]      product,
  input  logic             mult_end,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_product,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t          state, state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      fifo_count;
  logic [63:0]     entry1;
  logic            accept, end_hit, wd_hit, push, pop;

  assign in_ready  = (state == IDLE) && (fifo_count < 2'd2);
  assign out_valid = (fifo_count != 2'd0);
  assign accept    = in_valid && in_ready;
  // A zero watchdog count marks the first RUN cycle, where a stale end flag must not count.
  assign end_hit   = (state == RUN) && (wd_cnt != '0) && mult_end;
  assign wd_hit    = (state == RUN) && !end_hit && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign push      = end_hit;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (end_hit || wd_hit) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mult_begin <= 1'b0;
    end else begin
      state      <= state_nx;
      mult_begin <= (state_nx == RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_op1    <= '0;
      mult_op2    <= '0;
      wd_cnt      <= '0;
      done_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        mult_op1 <= in_op1;
        mult_op2 <= in_op2;
        wd_cnt   <= '0;
      end else if (state == RUN) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (push) done_cnt <= done_cnt + CNT_W'(1);
      if (wd_hit) err_timeout <= 1'b1;
    end
  end

  // Shift-style FIFO: out_product is the head register itself, entry1 the one behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count  <= 2'd0;
      out_product <= '0;
      entry1      <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) out_product <= product;
          else                    entry1      <= product;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          if (fifo_count == 2'd2) out_product <= entry1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            out_product <= product;
          end else begin
            out_product <= entry1;
            entry1      <= product;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Operand sequencer and result buffer placed directly upstream of the iterative `multiply` block.
- Accepts operand pairs on a valid/ready handshake and drives `mult_begin`, `mult_op1` and `mult_op2` for each operation.
- Holds `mult_begin` high until `mult_end`, captures `product`, then forces the one-cycle `mult_begin` low gap the multiplier needs before restarting.
- Buffers results in a 2-entry FIFO with valid/ready output.
- A watchdog flags a multiplier that never finishes.

## Interface
- `TIMEOUT`, 64: max cycles in RUN without `mult_end` before abort (≥ 2).
- `CNT_W`, 16: width of completed-operation counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in_op1`  in  32  multiplicand.
- `in_op2`  in  32  multiplier.
- `mult_begin`  out  1  to `multiply`; high for the whole operation.
- `mult_op1`  out  32  to `multiply`; latched operand 1.
- `mult_op2`  out  32  to `multiply`; latched operand 2.
- `product`  in  64  from `multiply`.
- `mult_end`  in  1  from `multiply`; result valid.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes FIFO head.
- `out_product`  out  64  FIFO head data.
- `done_cnt`  out  CNT_W  completed products pushed; wraps modulo 2^CNT_W.
- `err_timeout`  out  1  sticky; a watchdog abort occurred.

## Operation
- **States:** IDLE, RUN, GAP. Reset → IDLE.
- **`in_ready`:** `(state==IDLE) && (fifo_count < 2)`. At most one operation is in flight, so a push never overflows the FIFO.
- **IDLE:**
  - `mult_begin`=0.
  - On `in_valid && in_ready`: latch `in_op1`/`in_op2` into `mult_op1`/`mult_op2`, clear the watchdog counter, go to RUN.
- **RUN:**
  - `mult_begin`=1; watchdog counter increments every cycle.
  - `mult_end` is ignored in the first RUN cycle, so a stale end flag cannot be taken.
  - From the second RUN cycle on, `mult_end`=1 pushes `product` into the FIFO, increments `done_cnt`, and goes to GAP.
  - If the counter reaches `TIMEOUT-1` with no qualifying `mult_end`: set `err_timeout`, push nothing, go to GAP.
  - `mult_end` and timeout on the same cycle: the result wins and no error is flagged.
- **GAP:** `mult_begin`=0 for exactly one cycle, then IDLE.
- **Outside RUN:** `mult_end` and `product` are ignored.
- **Operand outputs:** `mult_op1`/`mult_op2` hold their value outside RUN; they change only on acceptance.
- **FIFO:**
  - 2 entries, first in first out.
  - Pop on `out_valid && out_ready`.
  - Simultaneous push and pop: count unchanged, order preserved.
  - `out_product` is the head entry and is stable while `out_valid && !out_ready`.
- **Arithmetic:** `product` is passed through bit-exact. No sign handling in this block; signedness is whatever `multiply` implements.
- **Reset:**
  - Values: state IDLE, `mult_begin`=0, `mult_op1`=`mult_op2`=0, FIFO empty, `out_valid`=0, `out_product`=0, `done_cnt`=0, `err_timeout`=0.
  - Reset mid-RUN aborts the operation with no push.
  - `err_timeout` clears only on reset.

## Timing
- Handshake accepted at edge k → `mult_begin`=1 and operands valid from cycle k+1.
- `mult_end` sampled high at edge m (RUN, not first cycle):
  - FIFO write at m; `out_valid`=1 from cycle m+1.
  - GAP in cycle m+1; IDLE and `in_ready` from m+2.
- Back-to-back issue: the next accept is earliest at edge m+2. Minimum one `mult_begin`-low cycle between operations.
- Timeout: the abort edge is the `TIMEOUT`-th RUN cycle after entry; `err_timeout`=1 from the following cycle.
- All outputs are registered except `in_ready` and `out_valid`, which are decoded from registered state only. No combinational path from any input to any output.

## Test plan
- **Basic op:** reset, then issue 0x00001111×0x00001111 → `mult_begin` high until `mult_end`, `out_product`=0x0000000001234321, `done_cnt`=1, `mult_begin` low for exactly one cycle after.
- **Stream:** issue 0x00001111×0x00002222, 0x00000002×0xFFFFFFFF, 0x00000002×0x80000000 back-to-back with `out_ready`=1 → outputs 0x0000000002468642, 0x00000001FFFFFFFE, 0x0000000100000000 in order; `in_ready` low during RUN and GAP.
- **Backpressure:** `out_ready`=0, offer 3 ops → two complete, `in_ready` stays low with count 2. One pop → third accepted; pop and push in the same cycle keep order.
- **Timeout:** bench multiplier model never asserts `mult_end` → after 64 RUN cycles `err_timeout`=1, no push, block returns to IDLE and completes the next op normally.
- **Reset mid-RUN:** assert `rst` 5 cycles into RUN → `mult_begin`=0 immediately, FIFO empty, `done_cnt`=0. After release, a new op completes correctly.
- **Random:** 1000 random operand pairs with random `out_ready` against a reference model → all products match, `done_cnt`=1000 mod 2^16, `err_timeout`=0.
